// File: rtl/mario_input_ctrl.sv
// Button front-end for the Mario character controller: 2-flop sync, debounce,
// last-pressed left/right arbitration and a length-bounded jump level.
module mario_input_ctrl #(
  parameter int DEB_CYCLES = 500000,
  parameter int JUMP_MAX   = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_jump,
  output logic left,
  output logic right,
  output logic jump,
  output logic jump_start
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int TW = $clog2(JUMP_MAX);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(JUMP_MAX - 1);

  // Bit order for all per-button vectors: [0] left, [1] right, [2] jump.
  logic [2:0]    sync_a;
  logic [2:0]    sync_b;
  logic [2:0]    stable;
  logic [2:0]    stable_q;
  logic [DW-1:0] deb_cnt [3];
  logic [2:0]    rise;
  logic [2:0]    fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a   <= '0;
      sync_b   <= '0;
      stable_q <= '0;
    end else begin
      sync_a   <= {btn_jump, btn_right, btn_left};
      sync_b   <= sync_a;
      stable_q <= stable;
    end
  end

  // A flip needs DEB_CYCLES consecutive disagreeing samples; any agreement restarts the count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        stable[i]  <= 1'b0;
        deb_cnt[i] <= '0;
      end else if (sync_b[i] == stable[i]) begin
        deb_cnt[i] <= '0;
      end else if (deb_cnt[i] == DEB_LAST) begin
        stable[i]  <= sync_b[i];
        deb_cnt[i] <= '0;
      end else begin
        deb_cnt[i] <= deb_cnt[i] + 1'b1;
      end
    end
  end

  assign rise = stable & ~stable_q;
  assign fall = ~stable & stable_q;

  typedef enum logic [1:0] {D_IDLE, D_LEFT, D_RIGHT} dir_t;
  typedef enum logic [1:0] {J_IDLE, J_ACTIVE, J_WAIT_REL} jmp_t;

  dir_t          dir_state;
  dir_t          dir_next;
  jmp_t          jmp_state;
  jmp_t          jmp_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;

  // Last-pressed wins; on a same-cycle tie out of idle, right wins.
  always_comb begin
    dir_next = dir_state;
    case (dir_state)
      D_IDLE: begin
        if (rise[1])      dir_next = D_RIGHT;
        else if (rise[0]) dir_next = D_LEFT;
      end
      D_LEFT: begin
        if (rise[1] || (fall[0] && stable[1])) dir_next = D_RIGHT;
        else if (fall[0])                      dir_next = D_IDLE;
      end
      D_RIGHT: begin
        if (rise[0] || (fall[1] && stable[0])) dir_next = D_LEFT;
        else if (fall[1])                      dir_next = D_IDLE;
      end
      default: dir_next = D_IDLE;
    endcase
  end

  // Release is checked before timeout so a same-cycle release lands in idle.
  always_comb begin
    jmp_next   = jmp_state;
    timer_next = timer;
    case (jmp_state)
      J_IDLE: begin
        if (rise[2]) begin
          jmp_next   = J_ACTIVE;
          timer_next = '0;
        end
      end
      J_ACTIVE: begin
        if (!stable[2]) begin
          jmp_next = J_IDLE;
        end else if (timer == TIMER_LAST) begin
          jmp_next = J_WAIT_REL;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      J_WAIT_REL: begin
        if (!stable[2]) jmp_next = J_IDLE;
      end
      default: jmp_next = J_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_state  <= D_IDLE;
      jmp_state  <= J_IDLE;
      timer      <= '0;
      left       <= 1'b0;
      right      <= 1'b0;
      jump       <= 1'b0;
      jump_start <= 1'b0;
    end else begin
      dir_state  <= dir_next;
      jmp_state  <= jmp_next;
      timer      <= timer_next;
      left       <= (dir_next == D_LEFT);
      right      <= (dir_next == D_RIGHT);
      jump       <= (jmp_next == J_ACTIVE);
      jump_start <= (jmp_state == J_IDLE) && (jmp_next == J_ACTIVE);
    end
  end

endmodule

// File: doc/mario_input_ctrl.md
Name: mario_input_ctrl

Overview:
- Front-end conditioner between the board push-buttons and the Mario character controller.
- Synchronises and debounces the raw left/right/jump buttons.
- Arbitrates left/right with last-pressed priority and shapes jump into a bounded press, so the character controller always sees clean, mutually exclusive `left`/`right` levels and a well-formed `jump` level.
- All outputs are registered and drive the controller's `left`, `right` and `jump` inputs directly.

Parameters:
- DEB_CYCLES, 500000, consecutive cycles a synchronised button must differ from its debounced state before that state flips (5 ms at 100 MHz); minimum 2.
- JUMP_MAX, 25000000, maximum number of cycles `jump` stays high per press (250 ms at 100 MHz); minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- btn_left  input  1  raw left button, asynchronous to clk, active-high.
- btn_right  input  1  raw right button, asynchronous, active-high.
- btn_jump  input  1  raw jump button, asynchronous, active-high.
- left  output  1  move-left level to the character controller.
- right  output  1  move-right level to the character controller.
- jump  output  1  jump-request level, bounded to JUMP_MAX cycles.
- jump_start  output  1  one-cycle pulse on the first cycle `jump` goes high.

Behaviour:
- Reset: on a rising clk edge with rst=1, all of the following clear to 0.
  - Synchroniser flops, debounced states and debounce counters.
  - Direction FSM goes to D_IDLE; jump FSM goes to J_IDLE; jump timer clears.
  - Outputs `left`, `right`, `jump`, `jump_start` are 0.
  - Reset mid-operation aborts everything. A button still held after reset is treated as a new press once it re-debounces.
- Synchroniser: each button passes through 2 flops. The second flop's output is the "sync" value.
- Debounce (per button, independent):
  - Counter increments each cycle that sync != stable; it clears whenever sync == stable.
  - On the cycle the counter equals DEB_CYCLES-1 with sync != stable, stable <= sync and the counter clears.
  - Net effect: a clean raw change first sampled at edge 1 updates stable at edge DEB_CYCLES+2.
  - A pulse or glitch lasting fewer than DEB_CYCLES cycles at the sync output is ignored.
- Direction FSM: states D_IDLE, D_LEFT, D_RIGHT. Outputs are registered: `left` = (state==D_LEFT), `right` = (state==D_RIGHT). They are never both high.
  - D_IDLE:
    - stable-left rising and stable-right not rising -> D_LEFT.
    - stable-right rising -> D_RIGHT; if both rise on the same cycle, right wins.
  - D_LEFT:
    - stable-right rising -> D_RIGHT.
    - stable-left falls with right held -> D_RIGHT.
    - stable-left falls with right not held -> D_IDLE.
  - D_RIGHT: mirror of D_LEFT. Simultaneous right fall and left rise -> D_LEFT.
  - Output latency: raw change first sampled at edge 1 -> output changes at edge DEB_CYCLES+3.
- Jump FSM: states J_IDLE, J_ACTIVE, J_WAIT_REL. `jump` = (state==J_ACTIVE).
  - J_IDLE:
    - stable-jump rising -> J_ACTIVE; timer <= 0.
    - `jump_start` is high for exactly that transition's following cycle, i.e. the first cycle `jump` is high.
  - J_ACTIVE:
    - Timer increments every cycle.
    - stable-jump low -> J_IDLE.
    - Else when timer == JUMP_MAX-1 -> J_WAIT_REL.
    - Net effect: `jump` is high for at most JUMP_MAX cycles.
  - J_WAIT_REL:
    - `jump` stays 0 while the button is held.
    - stable-jump low -> J_IDLE.
    - No re-trigger is possible without a debounced release.
  - Release and timeout on the same cycle resolve to J_IDLE.
- Jump and direction are independent; jumping while moving is allowed.
- Timer width is sufficient for JUMP_MAX-1. Debounce counter width is sufficient for DEB_CYCLES-1. No wrap-around is reachable.

Test Plan:
- DEB_CYCLES=4, JUMP_MAX=10 for all tests. rst=1 for 3 cycles with every button held high -> all outputs 0 during reset.
- Reset then held-button press -> after reset release, `right` rises 7 edges later and `jump`/`jump_start` rise 7 edges later.
- Glitch rejection: btn_left high for 3 cycles then low -> `left` never asserts. btn_left held 4+ cycles -> `left`=1 at edge 7.
- Last-pressed priority:
  - Hold left until `left`=1, then press right -> `right`=1 and `left`=0 at 7 edges after the right press.
  - Release right -> `left`=1 again 7 edges after the release.
- Jump timeout: hold btn_jump 40 cycles -> `jump` high exactly 10 cycles, `jump_start` high only on its first cycle; re-pressing without release gives no new jump.
- Early release: hold btn_jump, release 3 cycles after `jump` rises -> `jump` falls at the debounced release. A new press then produces a fresh 10-cycle-max jump.
- Mid-jump reset: assert rst while `jump`=1 -> `jump`=0 on the next edge. The button still held re-triggers 7 edges after rst deasserts.
